// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: takes a word over valid/ready and emits it
// one bit per clock, with a reload in the last-bit cycle for gap-free streaming.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] p_din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             s_dout,
  output logic             s_valid,
  output logic             s_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             at_last;
  logic             accept;

  assign at_last    = (cnt_q == LAST_CNT);
  assign load_ready = !rst && ((state_q == IDLE) || ((state_q == SHIFT) && at_last));
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = p_din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!at_last) begin
          cnt_d   = cnt_q + 1'b1;
          shreg_d = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[WIDTH-1:1]};
        end else if (accept) begin
          shreg_d = p_din;
          cnt_d   = '0;
        end else begin
          // Clearing here keeps s_dout and the register quiet between words.
          shreg_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  assign s_valid = (state_q == SHIFT);
  assign busy    = s_valid;
  assign s_last  = s_valid && at_last;
  assign s_dout  = s_valid && ((MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0]);

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: one MSB-first and one LSB-first instance,
// checked with immediate assertions against hand-derived bit sequences.
module tb_piso_shift_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_pdin, b_pdin;
  logic       a_lv, b_lv;
  logic       a_ready, a_dout, a_valid, a_last, a_busy;
  logic       b_ready, b_dout, b_valid, b_last, b_busy;
  logic [7:0] rx;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .p_din(a_pdin), .load_valid(a_lv), .load_ready(a_ready),
    .s_dout(a_dout), .s_valid(a_valid), .s_last(a_last), .busy(a_busy)
  );

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .p_din(b_pdin), .load_valid(b_lv), .load_ready(b_ready),
    .s_dout(b_dout), .s_valid(b_valid), .s_last(b_last), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleA(input string tag, input logic exp_ready);
    checkOutput({tag, "_valid"}, {7'd0, a_valid}, 8'd0);
    checkOutput({tag, "_busy"},  {7'd0, a_busy},  8'd0);
    checkOutput({tag, "_last"},  {7'd0, a_last},  8'd0);
    checkOutput({tag, "_dout"},  {7'd0, a_dout},  8'd0);
    checkOutput({tag, "_ready"}, {7'd0, a_ready}, {7'd0, exp_ready});
  endtask

  // Walks one word on the MSB-first instance starting in its first-bit cycle.
  // hold_lv keeps load_valid high all word; pulse_i raises it for one cycle;
  // end_lv offers end_w during the last-bit cycle.
  task automatic checkWordA(input string tag, input logic [7:0] seq, input logic hold_lv,
                            input int pulse_i, input logic [7:0] pulse_w,
                            input logic end_lv, input logic [7:0] end_w);
    rx = 8'd0;
    for (int i = 0; i < 8; i++) begin
      a_lv   = hold_lv || (i == pulse_i) || ((i == 7) && end_lv);
      a_pdin = (i == pulse_i) ? pulse_w : end_w;
      #1;
      checkOutput($sformatf("%s_dout%0d", tag, i),  {7'd0, a_dout},  {7'd0, seq[7-i]});
      checkOutput($sformatf("%s_valid%0d", tag, i), {7'd0, a_valid}, 8'd1);
      checkOutput($sformatf("%s_busy%0d", tag, i),  {7'd0, a_busy},  8'd1);
      checkOutput($sformatf("%s_last%0d", tag, i),  {7'd0, a_last},  {7'd0, (i == 7)});
      checkOutput($sformatf("%s_ready%0d", tag, i), {7'd0, a_ready}, {7'd0, (i == 7)});
      rx = {rx[6:0], a_dout};
      tick();
    end
    a_lv = 1'b0;
    checkOutput({tag, "_rx"}, rx, seq);
  endtask

  logic [7:0] lsb_seq;

  initial begin
    rst = 1'b1; a_lv = 1'b1; a_pdin = 8'hFF; b_lv = 1'b1; b_pdin = 8'hFF;

    // Reset held two cycles with a load offered: everything stays quiet.
    tick();
    checkIdleA("rst1", 1'b0);
    checkOutput("rst1_b_ready", {7'd0, b_ready}, 8'd0);
    tick();
    checkIdleA("rst2", 1'b0);
    checkOutput("rst2_b_valid", {7'd0, b_valid}, 8'd0);
    rst = 1'b0; a_lv = 1'b0; b_lv = 1'b0;
    #1;
    checkIdleA("rel", 1'b1);
    checkOutput("rel_b_ready", {7'd0, b_ready}, 8'd1);
    tick();
    checkIdleA("rel_nothing_loaded", 1'b1);

    // Single MSB-first word.
    a_pdin = 8'b1011_0010; a_lv = 1'b1;
    tick();
    checkWordA("msb", 8'b1011_0010, 1'b0, -1, 8'h00, 1'b0, 8'h00);
    checkIdleA("msb_idle", 1'b1);

    // LSB-first word on the second instance.
    lsb_seq = 8'b0100_1101;
    b_pdin = 8'b1011_0010; b_lv = 1'b1;
    tick();
    b_lv = 1'b0;
    rx = 8'd0;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("lsb_dout%0d", i),  {7'd0, b_dout},  {7'd0, lsb_seq[7-i]});
      checkOutput($sformatf("lsb_valid%0d", i), {7'd0, b_valid}, 8'd1);
      checkOutput($sformatf("lsb_last%0d", i),  {7'd0, b_last},  {7'd0, (i == 7)});
      rx = {b_dout, rx[7:1]};
      tick();
    end
    checkOutput("lsb_rx", rx, 8'b1011_0010);
    checkOutput("lsb_idle_valid", {7'd0, b_valid}, 8'd0);
    checkOutput("lsb_idle_ready", {7'd0, b_ready}, 8'd1);

    // Back-to-back: A5 then 3C with load_valid held.
    a_pdin = 8'hA5; a_lv = 1'b1;
    tick();
    checkWordA("b2b0", 8'hA5, 1'b1, -1, 8'h00, 1'b1, 8'h3C);
    checkWordA("b2b1", 8'h3C, 1'b0, -1, 8'h00, 1'b0, 8'h00);
    checkIdleA("b2b_idle", 1'b1);

    // Load pulse mid-word is ignored and never transmitted.
    a_pdin = 8'hF0; a_lv = 1'b1;
    tick();
    checkWordA("ign", 8'hF0, 1'b0, 3, 8'h0F, 1'b0, 8'h00);
    checkIdleA("ign_idle", 1'b1);
    tick();
    checkIdleA("ign_idle2", 1'b1);

    // Reset in bit 5 of C3 abandons the word.
    a_pdin = 8'hC3; a_lv = 1'b1;
    tick();
    a_lv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("mid_dout%0d", i), {7'd0, a_dout}, {7'd0, 8'hC3 >> (7 - i) & 8'd1});
      tick();
    end
    checkOutput("mid_bit5_dout", {7'd0, a_dout}, 8'd0);
    checkOutput("mid_bit5_last", {7'd0, a_last}, 8'd0);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_ready", {7'd0, a_ready}, 8'd0);
    tick();
    checkIdleA("mid_rst", 1'b0);
    rst = 1'b0;
    #1;
    checkIdleA("mid_rel", 1'b1);
    a_pdin = 8'h81; a_lv = 1'b1;
    tick();
    checkWordA("after_rst", 8'h81, 1'b0, -1, 8'h00, 1'b0, 8'h00);
    checkIdleA("after_rst_idle", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
